// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared types and helpers for the configuration frame writer
package config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        GAP,
        DONE
    } state_t;

    localparam int CFG_ADDR_WIDTH_DEFAULT = 5;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/config_gap_counter.sv
// rtl/config_gap_counter.sv - loadable down-counter with zero flag for inter-write idle cycles
module config_gap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - turns a serial bitstream into addressed single-cycle tile write strobes
module config_frame_writer
    import config_pkg::*;
#(
    parameter int ADDR_WIDTH = CFG_ADDR_WIDTH_DEFAULT,
    parameter int NUM_BITS   = 32,
    parameter int WRITE_GAP  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  bs_valid,
    input  logic                  bs_data,
    output logic                  bs_ready,
    output logic                  enable,
    output logic [0:ADDR_WIDTH-1] address,
    output logic                  data_in,
    output logic                  busy,
    output logic                  done
);

    // One spare counter bit so a full 2**ADDR_WIDTH frame can never wrap.
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam int                GAP_W    = (WRITE_GAP > 1) ? clog2(WRITE_GAP) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(NUM_BITS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic                  r_bs_ready;
    logic                  r_enable;
    logic [0:ADDR_WIDTH-1] r_address;
    logic                  r_data_in;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_handshake;
    logic                  w_last;
    logic                  w_gap_zero;

    assign w_handshake = r_bs_ready && bs_valid;
    assign w_last      = (r_count == LAST_BIT);

    generate
        if (WRITE_GAP > 0) begin : g_gap
            logic w_gap_load;
            logic w_gap_dec;

            // Loaded with WRITE_GAP-1 so GAP lasts exactly WRITE_GAP cycles.
            assign w_gap_load = (r_state == WRITE) && !w_last;
            assign w_gap_dec  = (r_state == GAP);

            config_gap_counter #(
                .WIDTH (GAP_W)
            ) u_gap_counter (
                .clk          (clk),
                .reset        (reset),
                .i_load       (w_gap_load),
                .i_load_value (GAP_W'(WRITE_GAP - 1)),
                .i_dec        (w_gap_dec),
                .o_zero       (w_gap_zero)
            );
        end else begin : g_no_gap
            assign w_gap_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ACCEPT;
                end
            end
            ACCEPT: begin
                if (w_handshake) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else if (WRITE_GAP > 0) begin
                    w_next_state = GAP;
                end else begin
                    w_next_state = ACCEPT;
                end
            end
            GAP: begin
                if (w_gap_zero) begin
                    w_next_state = ACCEPT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_bs_ready <= 1'b0;
            r_enable   <= 1'b0;
            r_address  <= '0;
            r_data_in  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_bs_ready <= (w_next_state == ACCEPT);
            r_enable   <= (w_next_state == WRITE);
            r_busy     <= (w_next_state == ACCEPT) || (w_next_state == WRITE) ||
                          (w_next_state == GAP);
            r_done     <= (w_next_state == DONE);

            if ((r_state == ACCEPT) && w_handshake) begin
                r_address <= r_count[ADDR_WIDTH-1:0];
                r_data_in <= bs_data;
            end

            if ((r_state == IDLE) && start) begin
                r_count <= '0;
            end else if ((r_state == WRITE) && !w_last) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bs_ready = r_bs_ready;
    assign enable   = r_enable;
    assign address  = r_address;
    assign data_in  = r_data_in;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_config_frame_writer.sv
// tb/tb_config_frame_writer.sv - randomized frame checks against a handshake-timing model
module tb_config_frame_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start;
    logic [3:0] bs_valid;
    logic [3:0] bs_data;
    logic [3:0] bs_ready;
    logic [3:0] enable;
    logic [3:0] data_in;
    logic [3:0] busy;
    logic [3:0] done;
    logic [0:4] address [4];

    int errors = 0;
    int checks = 0;
    int last_addr [4];
    bit last_data [4];

    always #5 clk = ~clk;

    // dut0: 4 bits no gap, dut1: 2 bits gap 3, dut2: full 32-bit frame, dut3: single bit
    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            config_frame_writer #(
                .ADDR_WIDTH (5),
                .NUM_BITS   ((g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 32 : 1),
                .WRITE_GAP  ((g == 1) ? 3 : 0)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .start    (start[g]),
                .bs_valid (bs_valid[g]),
                .bs_data  (bs_data[g]),
                .bs_ready (bs_ready[g]),
                .enable   (enable[g]),
                .address  (address[g]),
                .data_in  (data_in[g]),
                .busy     (busy[g]),
                .done     (done[g])
            );
        end
    endgenerate

    function automatic int nb_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 2 : (idx == 2) ? 32 : 1;
    endfunction

    function automatic int gap_of(input int idx);
        return (idx == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input int idx, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle%0d: observed=%0d expected=%0d", tag, idx, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset(input int idx, input int cyc);
        chk("rst_bs_ready", idx, cyc, bs_ready[idx], 0);
        chk("rst_enable",   idx, cyc, enable[idx],   0);
        chk("rst_address",  idx, cyc, address[idx],  0);
        chk("rst_data_in",  idx, cyc, data_in[idx],  0);
        chk("rst_busy",     idx, cyc, busy[idx],     0);
        chk("rst_done",     idx, cyc, done[idx],     0);
    endtask

    // mode 0: valid always high, 1: valid pattern 1,0,0 repeating, 2: random valid.
    // abort_k >= 0 asserts reset in the cycle after strobe abort_k.
    task automatic run_frame(input int idx, input int mode, input logic [31:0] bits_in,
                             input bit rand_bits, input int extra_t, input int abort_k);
        int nb;
        int gap;
        int len;
        int r;
        int t;
        int te;
        int pending;
        int ke;
        bit exp_rdy;
        bit bits [$];
        bit v [$];
        int hs [$];
        nb  = nb_of(idx);
        gap = gap_of(idx);
        for (int k = 0; k < nb; k++) begin
            bits.push_back(rand_bits ? 1'($urandom_range(0, 1)) : bits_in[k]);
        end
        len = nb * (gap + 8) + 20;
        for (int c = 0; c < len; c++) begin
            case (mode)
                0:       v.push_back(1'b1);
                1:       v.push_back((c % 3) == 1);
                default: v.push_back(((c % 4) == 0) || ($urandom_range(0, 2) == 0));
            endcase
        end
        // The writer is ready from edge r onward; a bit is taken at the first valid edge,
        // then it spends one write cycle plus the gap before being ready again.
        r = 1;
        for (int k = 0; k < nb; k++) begin
            t = r;
            while (!v[t] && (t < len - 1)) t++;
            hs.push_back(t);
            r = t + 2 + gap;
        end
        te = (abort_k >= 0) ? hs[abort_k] + 1 : hs[nb-1] + 3;

        for (int c = 0; c <= te; c++) begin
            pending = 0;
            foreach (hs[k]) if (hs[k] < c) pending++;
            start[idx]    = (c == 0) || (c == extra_t);
            bs_valid[idx] = v[c];
            bs_data[idx]  = (v[c] && (pending < nb)) ? bits[pending] : 1'($urandom_range(0, 1));
            reset         = (abort_k >= 0) && (c == te);
            @(posedge clk);
            @(negedge clk);
            if (reset) begin
                chk_reset(idx, c);
                for (int i = 0; i < 4; i++) begin
                    last_addr[i] = 0;
                    last_data[i] = 1'b0;
                end
            end else begin
                ke = -1;
                foreach (hs[k]) if (hs[k] == c) ke = k;
                exp_rdy = 1'b0;
                for (int k = 0; k < nb; k++) begin
                    int rk;
                    rk = (k == 0) ? 1 : hs[k-1] + 2 + gap;
                    if ((c >= rk - 1) && (c <= hs[k] - 1)) exp_rdy = 1'b1;
                end
                if (ke >= 0) begin
                    last_addr[idx] = ke;
                    last_data[idx] = bits[ke];
                end
                chk("enable",   idx, c, enable[idx],   (ke >= 0));
                chk("bs_ready", idx, c, bs_ready[idx], exp_rdy);
                chk("busy",     idx, c, busy[idx],     (c <= hs[nb-1]));
                chk("done",     idx, c, done[idx],     (c == hs[nb-1] + 1));
                chk("address",  idx, c, address[idx],  last_addr[idx]);
                chk("data_in",  idx, c, data_in[idx],  last_data[idx]);
            end
        end
        start    = '0;
        bs_valid = '0;
        bs_data  = '0;
        reset    = 1'b0;
    endtask

    initial begin
        start    = '0;
        bs_valid = '0;
        bs_data  = '0;
        reset    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            last_addr[i] = 0;
            last_data[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        start    = 4'b1111;
        bs_valid = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk_reset(i, -1);
        reset    = 1'b0;
        start    = '0;
        bs_valid = '0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("start_with_reset_busy",  i, 0, busy[i],     0);
            chk("start_with_reset_ready", i, 0, bs_ready[i], 0);
        end

        run_frame(0, 0, 32'b1101, 1'b0, -1, -1);
        run_frame(1, 0, 32'b0,    1'b1, -1, -1);
        run_frame(1, 2, 32'b0,    1'b1, -1, -1);
        run_frame(0, 1, 32'b0,    1'b1, -1, -1);
        run_frame(0, 0, 32'b0,    1'b1, -1,  1);
        run_frame(0, 0, 32'b0,    1'b1, -1, -1);
        run_frame(2, 0, 32'b0,    1'b1, -1, -1);
        run_frame(2, 2, 32'b0,    1'b1, -1, -1);
        run_frame(0, 0, 32'b0,    1'b1,  3, -1);
        run_frame(0, 2, 32'b0,    1'b1,  5, -1);
        run_frame(3, 0, 32'b0,    1'b1, -1, -1);
        run_frame(3, 2, 32'b0,    1'b1, -1, -1);
        run_frame(1, 2, 32'b0,    1'b1, -1,  0);
        run_frame(1, 0, 32'b0,    1'b1,  4, -1);
        for (int n = 0; n < 6; n++) begin
            run_frame(int'($urandom_range(0, 3)), 2, 32'b0, 1'b1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
